// File: rtl/pipe_skid_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buffer_if
// Purpose  : One valid/ready/data channel for pipe_skid_buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_skid_buffer_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buffer
// Purpose  : Fully registered valid/ready slice with a main + skid entry.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_buffer #(
    parameter int WIDTH      = 8,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_skid_buffer_if.slave       s,
    pipe_skid_buffer_if.master      m,
    output logic [1:0]              level
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_s_ready;
    logic             r_m_valid;
    logic [1:0]       r_level;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_s_fire;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;

    // s_ready is low for one cycle after reset even in EMPTY, so gate on it
    assign w_s_fire = s.valid & r_s_ready;

    always_comb begin
        w_next         = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_s_fire) begin
                    w_ld_main_in = 1'b1;
                    w_next       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                case ({w_s_fire, m.ready})
                    2'b11: w_ld_main_in = 1'b1;
                    2'b10: begin
                        w_ld_skid = 1'b1;
                        w_next    = ST_FULL;
                    end
                    2'b01: w_next = ST_EMPTY;
                    default: w_next = ST_BUSY;
                endcase
            end
            ST_FULL: begin
                if (m.ready) begin
                    w_ld_main_skid = 1'b1;
                    w_next         = ST_BUSY;
                end
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_level   <= 2'd0;
        end else begin
            r_state   <= w_next;
            r_s_ready <= (w_next != ST_FULL);
            r_m_valid <= (w_next != ST_EMPTY);
            r_level   <= w_next;
        end
    end

    generate
        if (CLEAR_DATA) begin : g_clear_data
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main <= '0;
                    r_skid <= '0;
                end else begin
                    if (w_ld_main_in) begin
                        r_main <= s.data;
                    end else if (w_ld_main_skid) begin
                        r_main <= r_skid;
                    end
                    if (w_ld_skid) begin
                        r_skid <= s.data;
                    end
                end
            end
        end else begin : g_keep_data
            // Data regs carry no reset; only the load enables are blocked
            always_ff @(posedge clk) begin
                if (!rst) begin
                    if (w_ld_main_in) begin
                        r_main <= s.data;
                    end else if (w_ld_main_skid) begin
                        r_main <= r_skid;
                    end
                    if (w_ld_skid) begin
                        r_skid <= s.data;
                    end
                end
            end
        end
    endgenerate

    assign s.ready = r_s_ready;
    assign m.valid = r_m_valid;
    assign m.data  = r_main;
    assign level   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_buffer
// Purpose  : Scoreboard bench for pipe_skid_buffer against a 2-deep queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_buffer;

    logic       clk;
    logic       rst;
    logic [1:0] level;

    pipe_skid_buffer_if #(.WIDTH(8)) up ();
    pipe_skid_buffer_if #(.WIDTH(8)) dn ();

    pipe_skid_buffer #(
        .WIDTH      (8),
        .CLEAR_DATA (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s     (up),
        .m     (dn),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Reference: a bounded FIFO of two entries whose ready flag is
    // registered from "fewer than two held"; reset empties it.
    logic [7:0] mq[$];
    bit         m_rdy     = 1'b0;
    bit         zero_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_rdy     = 1'b0;
                zero_flag = 1'b1;
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = (mq.size() != 0) && (dn.ready === 1'b1);
                do_push = (up.valid === 1'b1) && m_rdy;
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back(up.data);
                    zero_flag = 1'b0;
                end
                m_rdy = (mq.size() < 2);
            end
        end
    end

    // Monitor: every cycle the DUT's presented outputs must match the model head
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                check("m_valid", {31'd0, dn.valid}, {31'd0, mq.size() != 0});
                check("level",   {30'd0, level},    mq.size());
                check("s_ready", {31'd0, up.ready}, {31'd0, m_rdy});
                if (mq.size() != 0) begin
                    check("m_data", {24'd0, dn.data}, {24'd0, mq[0]});
                end else if (zero_flag) begin
                    check("m_data_cleared", {24'd0, dn.data}, 32'd0);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        up.valid = v;
        up.data  = d;
        dn.ready = r;
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst      = 1'b1;
        up.valid = 1'b1;
        up.data  = 8'hAA;
        dn.ready = 1'b0;

        // Reset with a pending upstream payload that must not be taken
        settle();
        mon_en = 1'b1;
        settle();
        check("rst_level",   {30'd0, level},    32'd0);
        check("rst_s_ready", {31'd0, up.ready}, 32'd0);
        check("rst_m_valid", {31'd0, dn.valid}, 32'd0);
        settle();
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("release_level", {30'd0, level},    32'd0);
        check("release_ready", {31'd0, up.ready}, 32'd1);

        // Streaming at full rate
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b1);
        settle();
        check("stream_level", {30'd0, level}, 32'd1);
        check("stream_last",  {24'd0, dn.data}, 32'h10);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Backpressure: 0x11 in main, 0x22 lands in skid, 0x33 held off
        drive(1'b1, 8'h11, 1'b1);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        settle();
        check("bp_level",   {30'd0, level},    32'd2);
        check("bp_s_ready", {31'd0, up.ready}, 32'd0);
        check("bp_head",    {24'd0, dn.data},  32'h11);
        drive(1'b1, 8'h33, 1'b1);
        drive(1'b1, 8'h33, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);

        // Drain from FULL
        drive(1'b1, 8'h66, 1'b1);
        drive(1'b1, 8'h77, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        settle();
        check("drain_l1", {30'd0, level}, 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        settle();
        check("drain_l0",    {30'd0, level},    32'd0);
        check("drain_valid", {31'd0, dn.valid}, 32'd0);

        // Reset while FULL drops both entries
        drive(1'b1, 8'h44, 1'b1);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        settle();
        check("full_level", {30'd0, level}, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        settle();
        check("rstfull_valid", {31'd0, dn.valid}, 32'd0);
        check("rstfull_level", {30'd0, level},    32'd0);
        check("rstfull_data",  {24'd0, dn.data},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);

        // Random traffic; upstream honours the hold rule while stalled
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (!(up.valid && !up.ready)) begin
                up.valid = 1'($urandom % 2);
                up.data  = 8'($urandom);
            end
            dn.ready = 1'($urandom % 2);
        end
        drive(up.valid, up.data, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);
        settle();
        check("final_level", {30'd0, level}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
